// File: rtl/rd_fifo_space_ctrl.sv
// rd_fifo_space_ctrl
//   Read-side FIFO status controller for the VDMA read path. It watches the
//   occupancy of the FIFO between the AXI read master (DDR -> FIFO) and the
//   video output. While the FIFO has room and the frame still has words left,
//   it requests fixed-length bursts. It then issues one short tail burst for
//   the remainder. A watchdog recovers a stuck transfer through rst_chain.
//
// Optional feature macro: RD_ERR_CNT_EN
//   When defined, adds err_cnt, a saturating count of timeout events.
//
// Ports
//   clock, rst        : clock, asynchronous active-high reset
//   enable            : allows new requests to be issued from IDLE
//   f_rst_status      : synchronous abort (state -> IDLE, remain cleared)
//   frame_start       : 1-cycle pulse that latches frame_len
//   frame_len         : number of words in the frame
//   count, fifo_empty : FIFO occupancy and empty flag
//   resp, done        : read master accepted request / last beat written
//   burst_req         : normal burst request level (req_len = BURST_LEN)
//   tail_req          : tail burst request level (req_len = remainder)
//   req_len           : length of the current request, held until the next
//   burst_done        : 1-cycle completion pulse for a normal burst
//   tail_done         : 1-cycle completion pulse for the tail burst
//   frame_done        : 1-cycle pulse when the frame's remaining count hits 0
//   frame_drop        : 1-cycle pulse for a frame_start that was ignored
//   rst_chain         : 1-cycle datapath reset request after a timeout
//   busy              : controller is outside IDLE
//   err_cnt           : (RD_ERR_CNT_EN only) timeout event count, saturating
module rd_fifo_space_ctrl #(
  parameter int          THRESHOLD = 300,
  parameter int          BURST_LEN = 100,
  parameter int          LSIZE     = 9,
  parameter int          DEPTH     = 1024,
  parameter logic [23:0] TIMEOUT   = 24'hFFF000
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       f_rst_status,
  input  logic                       frame_start,
  input  logic [23:0]                frame_len,
  input  logic [$clog2(DEPTH)-1:0]   count,
  input  logic                       fifo_empty,
  input  logic                       resp,
  input  logic                       done,
  output logic                       burst_req,
  output logic                       tail_req,
  output logic [LSIZE-1:0]           req_len,
  output logic                       burst_done,
  output logic                       tail_done,
  output logic                       frame_done,
  output logic                       frame_drop,
  output logic                       rst_chain,
  output logic                       busy
`ifdef RD_ERR_CNT_EN
  ,
  output logic [7:0]                 err_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    NEED_RD     = 4'd1,
    WAIT_DONE   = 4'd2,
    FSH         = 4'd3,
    RD_TAIL     = 4'd4,
    TAIL_DONE   = 4'd5,
    TAIL_FSH    = 4'd6,
    TIME_ERR    = 4'd7,
    RESET_CHAIN = 4'd8
  } state_t;

  state_t            cstate_q, nstate;
  logic [23:0]       remain_q, remain_d;
  logic [23:0]       tcnt_q;
  logic              timeout_q;
  logic              space_ok_q;
  logic              burst_req_q, tail_req_q, busy_q;
  logic              burst_done_q, tail_done_q, frame_done_q;
  logic              frame_drop_q, rst_chain_q;
  logic [LSIZE-1:0]  req_len_q;
  logic [31:0]       free_w;
  logic              load_ok;
  logic              wd_active;

  // Free words in the FIFO. Computed at 32 bits so the threshold compare
  // cannot wrap.
  assign free_w = 32'(DEPTH - 1) - 32'(count);

  // A new frame is accepted only when the previous frame is fully consumed
  // and no burst is in flight.
  assign load_ok = frame_start && (cstate_q == IDLE) && (remain_q == 24'd0);

  // The watchdog only counts toward a timeout in the states that wait on
  // the read master.
  assign wd_active = (cstate_q == NEED_RD) || (cstate_q == WAIT_DONE) ||
                     (cstate_q == RD_TAIL) || (cstate_q == TAIL_DONE) ||
                     (cstate_q == FSH)     || (cstate_q == TAIL_FSH);

  always_comb begin
    nstate = cstate_q;
    if (f_rst_status) begin
      nstate = IDLE;
    end else begin
      case (cstate_q)
        IDLE: begin
          if (enable && space_ok_q) begin
            if (remain_q >= 24'(BURST_LEN))  nstate = NEED_RD;
            else if (remain_q != 24'd0)      nstate = RD_TAIL;
          end
        end
        // Timeout outranks resp/done. If resp and done arrive in the same
        // cycle, that cycle counts as resp only, so done must be seen again.
        NEED_RD:     if (timeout_q) nstate = TIME_ERR; else if (resp) nstate = WAIT_DONE;
        WAIT_DONE:   if (timeout_q) nstate = TIME_ERR; else if (done) nstate = FSH;
        FSH:         nstate = IDLE;
        RD_TAIL:     if (timeout_q) nstate = TIME_ERR; else if (resp) nstate = TAIL_DONE;
        TAIL_DONE:   if (timeout_q) nstate = TIME_ERR; else if (done) nstate = TAIL_FSH;
        TAIL_FSH:    nstate = IDLE;
        TIME_ERR:    nstate = RESET_CHAIN;
        RESET_CHAIN: if (fifo_empty) nstate = IDLE;
        default:     nstate = IDLE;
      endcase
    end
  end

  // Remaining words in the frame. Abort, tail completion and timeout
  // recovery all clear it. A normal burst subtracts BURST_LEN when FSH
  // is entered.
  always_comb begin
    remain_d = remain_q;
    if (f_rst_status)                                       remain_d = 24'd0;
    else if (nstate == FSH)                                 remain_d = remain_q - 24'(BURST_LEN);
    else if (nstate == TAIL_FSH)                            remain_d = 24'd0;
    else if (cstate_q == RESET_CHAIN && nstate == IDLE)     remain_d = 24'd0;
    else if (load_ok)                                       remain_d = frame_len;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cstate_q     <= IDLE;
      remain_q     <= 24'd0;
      tcnt_q       <= 24'd0;
      timeout_q    <= 1'b0;
      space_ok_q   <= 1'b0;
      burst_req_q  <= 1'b0;
      tail_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
      tail_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
      rst_chain_q  <= 1'b0;
      req_len_q    <= '0;
    end else begin
      cstate_q   <= nstate;
      remain_q   <= remain_d;
      space_ok_q <= (free_w >= 32'(THRESHOLD));

      // The counter saturates so that a long stay in RESET_CHAIN cannot
      // wrap it.
      if (cstate_q == IDLE)          tcnt_q <= 24'd0;
      else if (tcnt_q != 24'hFFFFFF) tcnt_q <= tcnt_q + 24'd1;
      timeout_q <= wd_active && (tcnt_q > TIMEOUT);

      burst_req_q  <= (nstate == NEED_RD);
      tail_req_q   <= (nstate == RD_TAIL);
      busy_q       <= (nstate != IDLE);
      burst_done_q <= (nstate == FSH);
      tail_done_q  <= (nstate == TAIL_FSH);
      rst_chain_q  <= (nstate == TIME_ERR);
      frame_done_q <= ((nstate == FSH) && (remain_q == 24'(BURST_LEN))) ||
                      (nstate == TAIL_FSH);
      frame_drop_q <= frame_start && !load_ok;

      if (cstate_q == IDLE && nstate == NEED_RD)      req_len_q <= LSIZE'(BURST_LEN);
      else if (cstate_q == IDLE && nstate == RD_TAIL) req_len_q <= remain_q[LSIZE-1:0];
    end
  end

`ifdef RD_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Survives f_rst_status on purpose: it records the history of timeouts.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)                                              err_cnt_q <= 8'd0;
    else if (nstate == TIME_ERR && err_cnt_q != 8'hFF)   err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign burst_req  = burst_req_q;
  assign tail_req   = tail_req_q;
  assign req_len    = req_len_q;
  assign burst_done = burst_done_q;
  assign tail_done  = tail_done_q;
  assign frame_done = frame_done_q;
  assign frame_drop = frame_drop_q;
  assign rst_chain  = rst_chain_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rd_fifo_space_ctrl.sv
module tb_rd_fifo_space_ctrl;
  localparam int LSIZE = 9;

  // Event kinds seen by the monitor
  localparam int EV_BREQ  = 1;  // val = req_len
  localparam int EV_TREQ  = 2;  // val = req_len
  localparam int EV_BDONE = 3;  // val = frame_done
  localparam int EV_TDONE = 4;  // val = frame_done
  localparam int EV_DROP  = 5;
  localparam int EV_RCHN  = 6;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, f_rst_status = 1'b0, frame_start = 1'b0;
  logic fifo_empty = 1'b0, resp = 1'b0, done = 1'b0;
  logic [23:0] frame_len = 24'd0;
  logic [9:0]  count = 10'd0;
  logic burst_req, tail_req, burst_done, tail_done, frame_done;
  logic frame_drop, rst_chain, busy;
  logic [LSIZE-1:0] req_len;
`ifdef RD_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad = 0;
  ev_t exp_q[$];

  always #5 clock = ~clock;

  rd_fifo_space_ctrl #(
    .THRESHOLD(300), .BURST_LEN(100), .LSIZE(LSIZE), .DEPTH(1024), .TIMEOUT(24'd40)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .f_rst_status(f_rst_status),
    .frame_start(frame_start), .frame_len(frame_len), .count(count),
    .fifo_empty(fifo_empty), .resp(resp), .done(done),
    .burst_req(burst_req), .tail_req(tail_req), .req_len(req_len),
    .burst_done(burst_done), .tail_done(tail_done), .frame_done(frame_done),
    .frame_drop(frame_drop), .rst_chain(rst_chain), .busy(busy)
`ifdef RD_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  task automatic expect_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_frame(input int len);
    frame_len = 24'(len);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!(burst_req || tail_req) && n < 200) begin
      tick();
      n++;
    end
    if (!(burst_req || tail_req)) chk("wait_req_timeout", 0, 1);
  endtask

  task automatic give_resp();
    repeat (2) tick();
    resp = 1'b1;
    tick();
    resp = 1'b0;
  endtask

  task automatic give_done(input int dly);
    repeat (dly) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Monitor: every DUT event is popped against the scoreboard queue.
  task automatic mon_check(input int k, input int v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d want none @%0t", k, v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        bad++;
        $display("FAIL event: got kind=%0d val=%0d want kind=%0d val=%0d @%0t",
                 k, v, e.kind, e.val, $time);
      end
    end
  endtask

  initial begin : monitor
    logic pb, pt;
    pb = 1'b0;
    pt = 1'b0;
    forever begin
      @(negedge clock);
      if (rst) begin
        pb = 1'b0;
        pt = 1'b0;
      end else begin
        if (burst_req && !pb) mon_check(EV_BREQ, int'(req_len));
        if (tail_req && !pt)  mon_check(EV_TREQ, int'(req_len));
        if (burst_done)       mon_check(EV_BDONE, int'(frame_done));
        if (tail_done)        mon_check(EV_TDONE, int'(frame_done));
        if (frame_drop)       mon_check(EV_DROP, 1);
        if (rst_chain)        mon_check(EV_RCHN, 1);
        if (frame_done && !burst_done && !tail_done) begin
          total++;
          bad++;
          $display("FAIL stray_frame_done: got 1 want 0 @%0t", $time);
        end
        pb = burst_req;
        pt = tail_req;
      end
    end
  end

  initial begin : stim
    int n;
    // Reset state
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({burst_req, tail_req, burst_done, tail_done,
                          frame_done, frame_drop, rst_chain}), 0);
    chk("rst_req_len", int'(req_len), 0);
    rst = 1'b0;
    repeat (2) tick();

    // 250 words: 100 + 100 + tail of 50
    expect_ev(EV_BREQ, 100); expect_ev(EV_BDONE, 0);
    expect_ev(EV_BREQ, 100); expect_ev(EV_BDONE, 0);
    expect_ev(EV_TREQ, 50);  expect_ev(EV_TDONE, 1);
    enable = 1'b1;
    pulse_frame(250);
    repeat (3) begin
      wait_req();
      give_resp();
      give_done(20);
    end
    repeat (4) tick();
    chk("t1_idle", int'(busy), 0);

    // A zero-length frame is accepted silently
    pulse_frame(0);
    repeat (5) tick();
    chk("zero_len_idle", int'(busy), 0);

    // No room: free = 223 < 300
    count = 10'd800;
    repeat (2) tick();
    expect_ev(EV_DROP, 1);
    expect_ev(EV_BREQ, 100);
    pulse_frame(100);
    repeat (2) tick();
    pulse_frame(55);           // remain != 0 -> dropped
    repeat (10) tick();
    chk("no_space_no_req", int'(burst_req), 0);
    count = 10'd700;           // free = 323
    tick();
    chk("space_lat_1", int'(burst_req), 0);
    tick();
    chk("space_lat_2", int'(burst_req), 1);

    // frame_start during WAIT_DONE is dropped; remain stays 100
    expect_ev(EV_DROP, 1);
    expect_ev(EV_BDONE, 1);
    give_resp();
    repeat (3) tick();
    pulse_frame(77);
    give_done(10);
    repeat (4) tick();
    chk("t3_idle", int'(busy), 0);

    // Timeout: resp never arrives
    expect_ev(EV_BREQ, 100);
    expect_ev(EV_RCHN, 1);
    fifo_empty = 1'b0;
    pulse_frame(100);
    wait_req();
    n = 0;
    while (!rst_chain && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, 43);
    repeat (5) tick();
    chk("reset_chain_hold", int'(busy), 1);
    fifo_empty = 1'b1;
    tick();
    fifo_empty = 1'b0;
    chk("reset_chain_exit", int'(busy), 0);
    repeat (6) tick();
    chk("timeout_remain_clr", int'(burst_req), 0);
`ifdef RD_ERR_CNT_EN
    chk("err_cnt", int'(err_cnt), 1);
`endif

    // Abort in TAIL_DONE: no tail_done, no frame_done
    expect_ev(EV_TREQ, 30);
    pulse_frame(30);
    wait_req();
    give_resp();
    repeat (3) tick();
    f_rst_status = 1'b1;
    tick();
    f_rst_status = 1'b0;
    chk("abort_idle", int'(busy), 0);
    give_done(5);
    repeat (6) tick();
    chk("abort_remain_clr", int'(tail_req), 0);

    // Asynchronous reset mid NEED_RD
    expect_ev(EV_BREQ, 100);
    pulse_frame(100);
    wait_req();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_breq", int'(burst_req), 0);
    chk("async_rst_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("post_rst_idle", int'(busy | burst_req | tail_req), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
